// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: control-word field positions,
// fixed control words, phase encodings and opcode class codes.
package control_pkg;

  localparam int CW_W = 33;

  localparam int ALU_EN      = 32;
  localparam int B_SEL       = 31;
  localparam int FS_HI       = 30;
  localparam int FS_LO       = 26;
  localparam int REGB_EN     = 25;
  localparam int SA_HI       = 24;
  localparam int SA_LO       = 20;
  localparam int SB_HI       = 19;
  localparam int SB_LO       = 15;
  localparam int DA_HI       = 14;
  localparam int DA_LO       = 10;
  localparam int REG_WR      = 9;
  localparam int RAM_EN      = 8;
  localparam int RAM_WR      = 7;
  localparam int PC_EN       = 6;
  localparam int PC_FS_HI    = 5;
  localparam int PC_FS_LO    = 4;
  localparam int PC_IN_SEL   = 3;
  localparam int STATUS_LOAD = 2;
  localparam int NS_HI       = 1;
  localparam int NS_LO       = 0;

  // Instruction fetch: read RAM and increment the PC.
  localparam logic [CW_W-1:0] FETCH_CW = (CW_W'(1) << RAM_EN) | (CW_W'(1) << PC_FS_LO);
  localparam logic [CW_W-1:0] HALT_CW  = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } phase_t;

  localparam logic [2:0] CLS_ALU_REG = 3'd0;
  localparam logic [2:0] CLS_ALU_IMM = 3'd1;
  localparam logic [2:0] CLS_MEM     = 3'd2;
  localparam logic [2:0] CLS_BRANCH  = 3'd3;
  localparam logic [2:0] CLS_CBZ     = 3'd4;
  localparam logic [2:0] CLS_BCOND   = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

endpackage

// File: rtl/opcode_classifier.sv
// Maps the instruction register to the decoder class that should drive the
// control word. Earlier matches win where opcode patterns overlap.
module opcode_classifier
  import control_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [2:0]  decoder_select
);

  always_comb begin
    decoder_select = CLS_ILLEGAL;
    if (instruction[31:26] == 6'b000101)
      decoder_select = CLS_BRANCH;
    else if (instruction[31:25] == 7'b1011010)
      decoder_select = CLS_CBZ;
    else if (instruction[31:24] == 8'b01010100)
      decoder_select = CLS_BCOND;
    else if (instruction[31:23] == 9'b111110000)
      decoder_select = CLS_MEM;
    else if (instruction[28:26] == 3'b100)
      decoder_select = CLS_ALU_IMM;
    else if (instruction[27:25] == 3'b101)
      decoder_select = CLS_ALU_REG;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/EXEC/HALT sequencer: owns IR, decoder state and status,
// stalls on mem_ready. Optional perf counters via `SEQ_PERF_COUNTERS_EN.
module control_sequencer
  import control_pkg::*;
#(
  parameter int WORD_WIDTH = 64,
  parameter int CW_WIDTH   = 33
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] databus,
  input  logic                  mem_ready,
  input  logic [4:0]            alu_status,
  input  logic [CW_WIDTH-1:0]   decoded_controlword,
  input  logic [WORD_WIDTH-1:0] decoded_constant,
  output logic [31:0]           instruction,
  output logic [1:0]            state,
  output logic [4:0]            status,
  output logic [2:0]            decoder_select,
  output logic [CW_WIDTH-1:0]   controlword,
  output logic [WORD_WIDTH-1:0] constant,
  output logic                  halted
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           retired_count
`endif
);

  phase_t      phase, phase_next;
  logic [31:0] ir;
  logic [1:0]  dec_state;
  logic [4:0]  status_reg;
  logic        load_ir, load_status, step_state;

  // Only the low word of the bus carries instructions.
  logic unused_bus_bits;
  assign unused_bus_bits = ^databus[WORD_WIDTH-1:32];

  opcode_classifier u_classifier (
    .instruction    (ir),
    .decoder_select (decoder_select)
  );

  assign instruction = ir;
  assign state       = dec_state;
  assign status      = status_reg;
  assign halted      = (phase == HALT);

  always_comb begin
    controlword = CW_WIDTH'(FETCH_CW);
    constant    = '0;
    phase_next  = phase;
    load_ir     = 1'b0;
    load_status = 1'b0;
    step_state  = 1'b0;
    case (phase)
      FETCH: begin
        if (mem_ready) begin
          load_ir    = 1'b1;
          phase_next = EXEC;
        end else begin
          controlword[PC_FS_HI:PC_FS_LO] = 2'b00;
        end
      end
      EXEC: begin
        if (decoder_select == CLS_ILLEGAL) begin
          controlword = CW_WIDTH'(HALT_CW);
          phase_next  = HALT;
        end else begin
          controlword = decoded_controlword;
          constant    = decoded_constant;
          // A pending memory access freezes every side effect of this step.
          if ((controlword[RAM_EN] || controlword[RAM_WR]) && !mem_ready) begin
            controlword[REG_WR]            = 1'b0;
            controlword[RAM_WR]            = 1'b0;
            controlword[STATUS_LOAD]       = 1'b0;
            controlword[PC_FS_HI:PC_FS_LO] = 2'b00;
          end else begin
            load_status = controlword[STATUS_LOAD];
            if (controlword[NS_HI:NS_LO] != 2'b00)
              step_state = 1'b1;
            else
              phase_next = FETCH;
          end
        end
      end
      HALT: begin
        controlword = CW_WIDTH'(HALT_CW);
      end
      default: begin
        controlword = CW_WIDTH'(HALT_CW);
        phase_next  = FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase      <= FETCH;
      ir         <= '0;
      dec_state  <= '0;
      status_reg <= '0;
    end else begin
      phase <= phase_next;
      if (load_ir) begin
        ir        <= databus[31:0];
        dec_state <= 2'b00;
      end
      if (step_state)
        dec_state <= controlword[NS_HI:NS_LO];
      if (load_status)
        status_reg <= alu_status;
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic retire;
  assign retire = (phase == EXEC) && (phase_next == FETCH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (phase != HALT)
        cycle_count <= cycle_count + 32'd1;
      if (retire)
        retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle sequencer at the top of the control unit.
- Fetches the instruction into an instruction register (IR), classifies the opcode, and steers the per-class decoders via `decoder_select`.
- Issues their 33-bit control word to the datapath, tracks the 2-bit decoder state, and holds the 5-bit status register.
- Stalls on a RAM ready handshake and halts on illegal opcodes.

Parameters:
- WORD_WIDTH, 64, datapath/constant width.
- CW_WIDTH, 33, control word width (field order below).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- databus  input  64  RAM read data; instruction taken from bits [31:0] during FETCH.
- mem_ready  input  1  RAM ready; access completes in the cycle it is high.
- alu_status  input  5  ALU flags {V,C,N,Z,Zresult}; bit 0 drives CBZ/CBNZ.
- decoded_controlword  input  33  control word from the decoder selected by `decoder_select`.
- decoded_constant  input  64  constant from that same decoder.
- instruction  output  32  IR contents, fed to all decoders.
- state  output  2  decoder state, fed to decoders.
- status  output  5  status register, fed to decoders.
- decoder_select  output  3  opcode class.
- controlword  output  33  word applied to the datapath.
- constant  output  64  constant applied to the datapath.
- halted  output  1  high once an illegal opcode has been seen.

Behaviour:
- Control word field order, MSB to LSB:
  - alu_en[32], b_sel[31], fs[30:26], regb_en[25], SA[24:20], SB[19:15], DA[14:10], reg_wr[9], ram_en[8], ram_wr[7], pc_en[6], pc_fs[5:4], pc_in_sel[3], status_load[2], next_state[1:0].
- FSM states: FETCH, EXEC, HALT.
- Reset:
  - Phase is FETCH.
  - IR, state, status, counters are 0; halted is 0.
  - controlword is FETCH_CW, constant is 0.
- FETCH:
  - controlword = FETCH_CW: ram_en=1, pc_fs=01 (increment), all other fields 0.
  - While mem_ready=0: pc_fs is forced to 00 and nothing loads.
  - While mem_ready=1: IR <= databus[31:0], state <= 00, next phase EXEC.
- Classification is combinational from the IR, evaluated in priority order:
  - 3 (B): [31:26]=000101.
  - 4 (CBZ/CBNZ): [31:25]=1011010.
  - 5 (B.cond): [31:24]=01010100.
  - 2 (LDUR/STUR): [31:23]=111110000.
  - 1 (ALU immediate): [28:26]=100.
  - 0 (ALU register): [27:25]=101.
  - 7 (illegal): anything else.
- EXEC:
  - controlword and constant are passed through from the decoder.
  - Stall: if ram_en or ram_wr is set and mem_ready=0, force reg_wr=0, ram_wr=0, status_load=0, pc_fs=00. State, status and phase all hold.
  - Otherwise, at the clock edge:
    - If status_load=1: status <= alu_status.
    - If next_state != 00: state <= next_state, stay in EXEC.
    - If next_state == 00: go to FETCH.
- Illegal opcode:
  - From EXEC with decoder_select=7, go to HALT; the control word is forced to all-zero for that cycle.
- HALT:
  - controlword is all-zero, halted=1.
  - Only reset leaves HALT.
- Reset asserted mid-instruction aborts the instruction immediately. Outputs take reset values asynchronously.
- Latency: one instruction is a minimum of 2 cycles (FETCH plus 1 EXEC), plus 1 cycle per stall and per multi-state step.

Optional Feature:
- Macro: SEQ_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs `cycle_count[31:0]`, which increments every cycle not in HALT, and `retired_count[31:0]`, which increments on each EXEC to FETCH transition.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `control_pkg` holds:
  - Control word field bit-position localparams.
  - FETCH_CW and the HALT all-zero word.
  - Phase encodings FETCH=2'd0, EXEC=2'd1, HALT=2'd2.
  - Class codes 0–5 and ILLEGAL=7.
- One sub-module, `opcode_classifier`: pure combinational map from IR to decoder_select.

Test Plan:
- Reset then mem_ready=1, databus=0xB4000041 (CBZ X1):
  - Cycle 0: FETCH_CW with pc_fs=01.
  - Next cycle: decoder_select=4, controlword equals the driven decoded_controlword.
  - Then back to FETCH.
- LDUR fetch with mem_ready held 0 for 3 cycles: FETCH persists 3 cycles with pc_fs=00, IR unchanged; loads on cycle 4.
- EXEC word with next_state=01 then 00: state output shows 00 then 01, then FETCH. Retired count increments exactly once (with SEQ_PERF_COUNTERS_EN).
- EXEC word with status_load=1, alu_status=5'b00001: status=00001 next cycle. With status_load=0 the status register does not change.
- IR=0x00000000: decoder_select=7, the next cycle is HALT, halted=1, controlword=0. Remains halted for 10 cycles regardless of inputs.
- Reset pulled low during a stalled EXEC: outputs return to reset values without a clock edge; after release, FETCH restarts.
